life_gen_sched: RTL

- Schedules Game of Life generation updates against the VGA raster.
- Decides when the cell-update engine starts a new generation and grants the engine the shared cell-RAM port only during vertical blanking.
- Flips the double-buffered display/compute buffer select at frame boundaries.
- Sits between the sync generator (hpos/vpos), the update engine and the cell-RAM mux.

---
 rtl/life_gen_sched_if.sv | 22 ++
 rtl/life_gen_sched.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/life_gen_sched_if.sv
// Engine handshake between the generation scheduler and the cell-update engine.
// The scheduler side is the master: it issues gen_start and owns the grant.
interface life_gen_sched_if;
  logic gen_start;
  logic gen_done;
  logic eng_req;
  logic eng_gnt;

  modport master (
    output gen_start,
    output eng_gnt,
    input  gen_done,
    input  eng_req
  );

  modport slave (
    input  gen_start,
    input  eng_gnt,
    output gen_done,
    output eng_req
  );
endinterface

// File: rtl/life_gen_sched.sv
// Game of Life generation scheduler: paces generations against the VGA raster,
// grants the engine the cell-RAM port in vblank and flips the display buffer.
module life_gen_sched #(
  parameter int FRAMES_PER_GEN = 8,
  parameter int H_LAST         = 799,
  parameter int V_LAST         = 524,
  parameter int V_VIS          = 480,
  parameter int GUARD          = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [9:0]             hpos,
  input  logic [9:0]             vpos,
  input  logic                   run,
  input  logic                   step,
  life_gen_sched_if.master       eng,
  output logic                   disp_buf,
  output logic                   busy,
  output logic                   overrun,
  output logic [15:0]            gen_count
);

  localparam logic [9:0] H_END    = 10'(H_LAST);
  localparam logic [9:0] V_END    = 10'(V_LAST);
  localparam logic [9:0] V_BLANK  = 10'(V_VIS);
  localparam logic [9:0] GNT_STOP = 10'(H_LAST - GUARD + 1);
  localparam logic [7:0] FPG_LAST = 8'(FRAMES_PER_GEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RUN,
    WAIT_SWAP
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  frame_cnt, frame_cnt_nxt;
  logic        gen_start_q, gen_start_nxt;
  logic        eng_gnt_q, eng_gnt_nxt;
  logic        overrun_nxt;
  logic        disp_buf_nxt;
  logic [15:0] gen_count_nxt;

  logic frame_end;
  logic vbl_start;
  logic in_vblank;
  logic in_guard;

  assign frame_end = (hpos == H_END) && (vpos == V_END);
  assign vbl_start = (hpos == '0) && (vpos == V_BLANK);
  assign in_vblank = (vpos >= V_BLANK);
  // The grant is pulled back a few cycles before the raster wraps so the
  // display side regains the RAM port before the first visible pixel.
  assign in_guard  = (vpos == V_END) && (hpos >= GNT_STOP);

  assign eng_gnt_nxt = eng.eng_req && in_vblank && !in_guard;

  // NOTE: every signal driven here gets its default first, so no path through
  // the case statement leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt     = state;
    frame_cnt_nxt = frame_cnt;
    gen_start_nxt = 1'b0;
    overrun_nxt   = 1'b0;
    disp_buf_nxt  = disp_buf;
    gen_count_nxt = gen_count;

    unique case (state)
      IDLE: begin
        if (run) begin
          if (frame_end) begin
            if (frame_cnt == FPG_LAST) begin
              frame_cnt_nxt = '0;
              state_nxt     = ARMED;
            end else begin
              frame_cnt_nxt = frame_cnt + 8'd1;
            end
          end
        end else begin
          frame_cnt_nxt = '0;
          if (step) state_nxt = ARMED;
        end
      end

      ARMED: begin
        if (vbl_start) begin
          state_nxt     = RUN;
          gen_start_nxt = 1'b1;
        end
      end

      RUN: begin
        // A completion that coincides with frame_end is not an overrun; the
        // swap simply waits for the next frame boundary.
        if (eng.gen_done) begin
          state_nxt = WAIT_SWAP;
        end else if (frame_end) begin
          overrun_nxt = 1'b1;
        end
      end

      WAIT_SWAP: begin
        if (frame_end) begin
          disp_buf_nxt  = ~disp_buf;
          gen_count_nxt = gen_count + 16'd1;
          frame_cnt_nxt = '0;
          state_nxt     = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      frame_cnt   <= '0;
      gen_start_q <= 1'b0;
      eng_gnt_q   <= 1'b0;
      overrun     <= 1'b0;
      disp_buf    <= 1'b0;
      gen_count   <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      frame_cnt   <= frame_cnt_nxt;
      gen_start_q <= gen_start_nxt;
      eng_gnt_q   <= eng_gnt_nxt;
      overrun     <= overrun_nxt;
      disp_buf    <= disp_buf_nxt;
      gen_count   <= gen_count_nxt;
      busy        <= (state_nxt != IDLE);
    end
  end

  assign eng.gen_start = gen_start_q;
  assign eng.eng_gnt   = eng_gnt_q;

endmodule
